// File: rtl/dmem_pkg.sv
// Shared types and the load lane-select/extend helper for the banked data memory.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    // Word is passed at 64 bits so one helper serves both XLEN builds; callers truncate.
    function automatic logic [63:0] load_extend(
        input logic [63:0] word,
        input logic [2:0]  off,
        input size_e       size,
        input logic        is_unsigned
    );
        logic [63:0] sh;
        logic [63:0] res;
        sh = word >> {off, 3'b000};
        case (size)
            SZ_B:    res = is_unsigned ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
            SZ_H:    res = is_unsigned ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
            SZ_W:    res = is_unsigned ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_read_pipe.sv
// Fixed-latency load response pipeline; each stage's data only advances with a valid,
// so the last stage holds the most recent result between pulses.
module dmem_read_pipe #(
    parameter int unsigned XLEN         = 64,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic            clk,
    input  logic            flush,
    input  logic            in_valid,
    input  logic [XLEN-1:0] in_data,
    input  logic            in_flag,
    output logic            out_valid,
    output logic [XLEN-1:0] out_data,
    output logic            out_flag
);

    logic [READ_LATENCY-1:0] valid_q;
    logic [READ_LATENCY-1:0] flag_q;
    logic [XLEN-1:0]         data_q [READ_LATENCY];

    always_ff @(posedge clk) begin
        if (flush) begin
            valid_q <= '0;
            flag_q  <= '0;
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            flag_q[0]  <= in_valid & in_flag;
            if (in_valid) begin
                data_q[0] <= in_data;
            end
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                flag_q[i]  <= flag_q[i-1];
                if (valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign out_valid = valid_q[READ_LATENCY-1];
    assign out_flag  = flag_q[READ_LATENCY-1];
    assign out_data  = data_q[READ_LATENCY-1];

endmodule

// File: rtl/data_memory_banked.sv
// Byte-lane data memory with post-reset clear FSM and fixed-latency loads.
// DMEM_MISALIGN_TRAP_EN: suppress misaligned accesses and flag them on misalignOutput.
module data_memory_banked
    import dmem_pkg::*;
#(
    parameter int unsigned XLEN         = 64,
    parameter int unsigned DEPTH        = 64,
    parameter int unsigned ADDR_W       = 48,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              clockInput,
    input  logic              resetInput,
    input  logic              reqValidInput,
    output logic              reqReadyOutput,
    input  logic              memWriteInput,
    input  logic              memReadInput,
    input  logic [ADDR_W-1:0] addressInput,
    input  logic [1:0]        sizeInput,
    input  logic              unsignedInput,
    input  logic [XLEN-1:0]   writeDataInput,
    output logic [XLEN-1:0]   readDataOutput,
    output logic              readValidOutput,
    output logic              misalignOutput
);

    localparam int unsigned NB  = XLEN / 8;
    localparam int unsigned OFF = $clog2(NB);
    localparam int unsigned IDX = $clog2(DEPTH);

    state_e          state;
    logic [IDX-1:0]  clr_idx;
    logic [XLEN-1:0] mem [DEPTH];

    logic            accept;
    size_e           eff_size;
    logic [OFF-1:0]  off_raw;
    logic [OFF-1:0]  off_eff;
    logic [OFF-1:0]  low_mask;
    logic [IDX-1:0]  word_idx;
    logic            mis;
    logic [7:0]      span;
    logic [NB-1:0]   lane_en;
    logic [XLEN-1:0] wdata_sh;
    logic            do_store;
    logic            do_load;
    logic [63:0]     ext_word;
    logic [XLEN-1:0] load_data;
    logic            store_mis_q;
    logic            pipe_mis;
    logic            unused_addr;

    assign accept      = reqValidInput & reqReadyOutput;
    assign off_raw     = addressInput[OFF-1:0];
    assign word_idx    = addressInput[OFF+IDX-1:OFF];
    assign unused_addr = ^addressInput[ADDR_W-1:OFF+IDX];

    always_comb begin
        eff_size = size_e'(sizeInput);
        if (XLEN == 32 && sizeInput == 2'd3) begin
            eff_size = SZ_W;
        end
        low_mask = OFF'((4'd1 << eff_size) - 4'd1);
`ifdef DMEM_MISALIGN_TRAP_EN
        mis     = |(off_raw & low_mask);
        off_eff = off_raw;
`else
        mis     = 1'b0;
        off_eff = off_raw & ~low_mask;
`endif
        case (eff_size)
            SZ_B:    span = 8'h01;
            SZ_H:    span = 8'h03;
            SZ_W:    span = 8'h0F;
            default: span = 8'hFF;
        endcase
        lane_en  = NB'(span << off_eff);
        wdata_sh = writeDataInput << {off_eff, 3'b000};
        do_store = accept & memWriteInput & ~mis;
        do_load  = accept & memReadInput & ~memWriteInput;
        ext_word = load_extend(64'(mem[word_idx]), 3'(off_eff), eff_size, unsignedInput);
        load_data = mis ? '0 : ext_word[XLEN-1:0];
    end

    always_ff @(posedge clockInput) begin
        if (resetInput) begin
            state          <= CLEAR;
            clr_idx        <= '0;
            reqReadyOutput <= 1'b0;
            store_mis_q    <= 1'b0;
        end else begin
            store_mis_q <= accept & memWriteInput & mis;
            case (state)
                CLEAR: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == IDX'(DEPTH - 1)) begin
                        state          <= READY;
                        reqReadyOutput <= 1'b1;
                    end
                end
                default: reqReadyOutput <= 1'b1;
            endcase
        end
    end

    // The array itself is not reset; the CLEAR sweep zeroes it one word per cycle.
    always_ff @(posedge clockInput) begin
        if (state == CLEAR) begin
            mem[clr_idx] <= '0;
        end else if (do_store && !resetInput) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (lane_en[i]) begin
                    mem[word_idx][i*8 +: 8] <= wdata_sh[i*8 +: 8];
                end
            end
        end
    end

    dmem_read_pipe #(
        .XLEN         (XLEN),
        .READ_LATENCY (READ_LATENCY)
    ) u_read_pipe (
        .clk       (clockInput),
        .flush     (resetInput),
        .in_valid  (do_load),
        .in_data   (load_data),
        .in_flag   (mis),
        .out_valid (readValidOutput),
        .out_data  (readDataOutput),
        .out_flag  (pipe_mis)
    );

    assign misalignOutput = pipe_mis | store_mis_q;

endmodule

// File: tb/tb_data_memory_banked.sv
// Directed bench for data_memory_banked with a byte-array reference model.
module tb_data_memory_banked;

    localparam int XLEN   = 64;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 48;
    localparam int RL     = 3;
    localparam int NB     = XLEN / 8;

    logic              clockInput = 1'b0;
    logic              resetInput = 1'b1;
    logic              reqValidInput = 1'b0;
    logic              reqReadyOutput;
    logic              memWriteInput = 1'b0;
    logic              memReadInput = 1'b0;
    logic [ADDR_W-1:0] addressInput = '0;
    logic [1:0]        sizeInput = '0;
    logic              unsignedInput = 1'b0;
    logic [XLEN-1:0]   writeDataInput = '0;
    logic [XLEN-1:0]   readDataOutput;
    logic              readValidOutput;
    logic              misalignOutput;

    data_memory_banked #(
        .XLEN         (XLEN),
        .DEPTH        (DEPTH),
        .ADDR_W       (ADDR_W),
        .READ_LATENCY (RL)
    ) dut (
        .clockInput      (clockInput),
        .resetInput      (resetInput),
        .reqValidInput   (reqValidInput),
        .reqReadyOutput  (reqReadyOutput),
        .memWriteInput   (memWriteInput),
        .memReadInput    (memReadInput),
        .addressInput    (addressInput),
        .sizeInput       (sizeInput),
        .unsignedInput   (unsignedInput),
        .writeDataInput  (writeDataInput),
        .readDataOutput  (readDataOutput),
        .readValidOutput (readValidOutput),
        .misalignOutput  (misalignOutput)
    );

    always #5 clockInput = ~clockInput;

    int ecnt = 0;
    always @(posedge clockInput) ecnt++;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h (edge %0d)", name, act, exp, ecnt);
    endtask

    // Reference model: flat byte array plus queues of expected response times.
    typedef struct {
        int          due;
        logic [63:0] data;
        logic        mis;
    } exp_t;

    logic [7:0]  mbytes [DEPTH*NB];
    exp_t        expq [$];
    int          smisq [$];
    logic [63:0] seen [$];
    logic        seen_mis [$];
    int          seen_t [$];
    int          pulse_cnt = 0;
    int          last_rst = 0;
    logic        model_ready = 1'b0;
    logic [63:0] model_last = '0;
    logic        exp_v, exp_m;

    function automatic logic [63:0] m_load(input logic [47:0] addr, input logic [1:0] sz,
                                           input logic uns, output logic mis);
        int n = 1 << sz;
        int a = int'(addr % 48'(DEPTH*NB));
        logic [63:0] v = '0;
        mis = (a % n) != 0;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (mis) return '0;
`else
        a   = a - (a % n);
        mis = 1'b0;
`endif
        for (int i = 0; i < n; i++) v[8*i +: 8] = mbytes[a+i];
        if (!uns && n < 8 && v[8*n-1]) v = v | (~64'h0 << (8*n));
        return v;
    endfunction

    function automatic logic m_store(input logic [47:0] addr, input logic [1:0] sz,
                                     input logic [63:0] wd);
        int n = 1 << sz;
        int a = int'(addr % 48'(DEPTH*NB));
        logic mis = (a % n) != 0;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (mis) return 1'b1;
`else
        a   = a - (a % n);
        mis = 1'b0;
`endif
        for (int i = 0; i < n; i++) mbytes[a+i] = wd[8*i +: 8];
        return mis;
    endfunction

    always @(negedge clockInput) begin
        if (ecnt >= 1) begin
            if (resetInput) begin
                expq.delete();
                smisq.delete();
                last_rst   = ecnt;
                model_last = '0;
                for (int i = 0; i < DEPTH*NB; i++) mbytes[i] = 8'h00;
            end
            model_ready = !resetInput && (ecnt - last_rst >= DEPTH);
            exp_v = 1'b0;
            exp_m = 1'b0;
            if (expq.size() > 0 && expq[0].due == ecnt) begin
                exp_v      = 1'b1;
                exp_m      = expq[0].mis;
                model_last = expq[0].data;
                void'(expq.pop_front());
            end
            if (smisq.size() > 0 && smisq[0] == ecnt) begin
                exp_m = 1'b1;
                void'(smisq.pop_front());
            end
            check("ready", reqReadyOutput, model_ready);
            check("valid", readValidOutput, exp_v);
            check("data", readDataOutput, model_last);
            check("misalign", misalignOutput, exp_m);
            if (readValidOutput) begin
                seen.push_back(readDataOutput);
                seen_mis.push_back(misalignOutput);
                seen_t.push_back(ecnt);
                pulse_cnt++;
            end
        end
    end

    task automatic step();
        @(negedge clockInput);
        #1;
    endtask

    task automatic idle();
        reqValidInput = 1'b0;
        memWriteInput = 1'b0;
        memReadInput  = 1'b0;
    endtask

    task automatic drive(input logic wr, input logic rd, input logic [47:0] addr,
                         input logic [1:0] sz, input logic uns, input logic [63:0] wd);
        logic        m;
        logic [63:0] d;
        reqValidInput  = 1'b1;
        memWriteInput  = wr;
        memReadInput   = rd;
        addressInput   = addr;
        sizeInput      = sz;
        unsignedInput  = uns;
        writeDataInput = wd;
        if (model_ready && !resetInput) begin
            if (wr) begin
                if (m_store(addr, sz, wd)) smisq.push_back(ecnt + 1);
            end else if (rd) begin
                d = m_load(addr, sz, uns, m);
                expq.push_back('{due: ecnt + RL, data: d, mis: m});
            end
        end
    endtask

    task automatic ld(input logic [47:0] addr, input logic [1:0] sz, input logic uns);
        drive(1'b0, 1'b1, addr, sz, uns, '0);
        step();
        idle();
    endtask

    task automatic st(input logic [47:0] addr, input logic [1:0] sz, input logic [63:0] wd);
        drive(1'b1, 1'b0, addr, sz, 1'b0, wd);
        step();
        idle();
    endtask

    task automatic expect_pulses(input int target, input string name);
        for (int k = 0; k < 20 && seen.size() < target; k++) step();
        if (seen.size() < target) check({name, "_timeout"}, 64'(seen.size()), 64'(target));
    endtask

    int b;
    int cnt;
    int p0;

    initial begin
        repeat (3) step();
        resetInput = 1'b0;

        // Clear sweep: a store offered while not ready must be dropped.
        drive(1'b1, 1'b0, 48'h0, 2'd3, 1'b0, '1);
        step();
        idle();
        cnt = 1;
        while (!reqReadyOutput && cnt < 200) begin
            step();
            cnt++;
        end
        check("clear_cycles", 64'(cnt), 64'd64);
        b = seen.size();
        ld(48'h0, 2'd3, 1'b0);
        ld(48'h1F8, 2'd3, 1'b0);
        expect_pulses(b + 2, "cleared");
        check("ld_0_cleared", seen[b], 64'h0);
        check("ld_1f8_cleared", seen[b+1], 64'h0);

        // Extension and lane selection.
        st(48'h8, 2'd3, 64'h8877665544332211);
        b = seen.size();
        ld(48'hF, 2'd0, 1'b0);
        ld(48'hF, 2'd0, 1'b1);
        ld(48'hA, 2'd1, 1'b0);
        ld(48'hC, 2'd2, 1'b0);
        expect_pulses(b + 4, "ext");
        check("lb_f", seen[b], 64'hFFFF_FFFF_FFFF_FF88);
        check("lbu_f", seen[b+1], 64'h88);
        check("lh_a", seen[b+2], 64'h4433);
        check("lw_c", seen[b+3], 64'hFFFF_FFFF_8877_6655);

        // Byte store keeps the other lanes.
        st(48'h9, 2'd0, 64'hAA);
        b = seen.size();
        ld(48'h8, 2'd3, 1'b0);
        expect_pulses(b + 1, "sb");
        check("sb_merge", seen[b], 64'h8877_6655_4433_AA11);

        // Misaligned accesses.
        b = seen.size();
        ld(48'h9, 2'd1, 1'b0);
        expect_pulses(b + 1, "lh_mis");
`ifdef DMEM_MISALIGN_TRAP_EN
        check("lh_9_data", seen[b], 64'h0);
        check("lh_9_flag", 64'(seen_mis[b]), 64'd1);
`else
        check("lh_9_data", seen[b], 64'hFFFF_FFFF_FFFF_AA11);
        check("lh_9_flag", 64'(seen_mis[b]), 64'd0);
`endif
        st(48'h2, 2'd2, 64'hDEADBEEF);
        b = seen.size();
        ld(48'h0, 2'd3, 1'b0);
        expect_pulses(b + 1, "sw_mis");
`ifdef DMEM_MISALIGN_TRAP_EN
        check("sw_2_word0", seen[b], 64'h0);
`else
        check("sw_2_word0", seen[b], 64'h0000_0000_DEAD_BEEF);
`endif

        // Address aliasing with store-then-load on the next cycle.
        st(48'h208, 2'd3, 64'h0123_4567_89AB_CDEF);
        b = seen.size();
        ld(48'h008, 2'd3, 1'b0);
        ld(48'h208, 2'd3, 1'b0);
        expect_pulses(b + 2, "alias");
        check("alias_008", seen[b], 64'h0123_4567_89AB_CDEF);
        check("alias_208", seen[b+1], 64'h0123_4567_89AB_CDEF);

        // Back-to-back loads, then reset with loads in flight.
        b = seen.size();
        ld(48'h8, 2'd3, 1'b0);
        ld(48'hF, 2'd0, 1'b1);
        ld(48'h9, 2'd0, 1'b0);
        ld(48'hA, 2'd1, 1'b0);
        expect_pulses(b + 4, "b2b");
        check("b2b_0", seen[b], 64'h0123_4567_89AB_CDEF);
        check("b2b_1", seen[b+1], 64'h01);
        check("b2b_2", seen[b+2], 64'hFFFF_FFFF_FFFF_FFCD);
        check("b2b_3", seen[b+3], 64'hFFFF_FFFF_FFFF_89AB);
        check("b2b_spacing", 64'(seen_t[b+3] - seen_t[b]), 64'd3);

        p0 = pulse_cnt;
        ld(48'h8, 2'd3, 1'b0);
        ld(48'h10, 2'd3, 1'b0);
        ld(48'h18, 2'd3, 1'b0);
        ld(48'h20, 2'd3, 1'b0);
        resetInput = 1'b1;
        step();
        step();
        resetInput = 1'b0;
        repeat (6) step();
        check("pulses_before_reset", 64'(pulse_cnt - p0), 64'd2);
        cnt = 0;
        while (!reqReadyOutput && cnt < 200) begin
            step();
            cnt++;
        end
        check("ready_after_reset", 64'(reqReadyOutput), 64'd1);
        b = seen.size();
        ld(48'h8, 2'd3, 1'b0);
        expect_pulses(b + 1, "post_reset");
        check("post_reset_ld", seen[b], 64'h0);

        repeat (5) step();
        check("drained", 64'(expq.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
